// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX byte-to-word packer.
package uart_pkg;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_WRITE   = 1'b1
  } rxpack_state_e;

  localparam int UART_BYTES_PER_WORD  = 4;
  localparam int UART_RX_TIMEOUT_BITS = 40;

  // Bytes held by the packer: filled lanes plus the back-pressure hold byte.
  function automatic logic [2:0] held_bytes(input logic [2:0] cnt, input logic hold_vld);
    return cnt + {2'b00, hold_vld};
  endfunction

endpackage

// File: rtl/uart_rx_pack_if.sv
// Byte strobe from the UART RX IP and word write port toward the RX FIFO.
interface uart_rx_pack_if;

  logic        uart_rxvld_i;
  logic [7:0]  uart_rxdata_i;
  logic        rxfifo_full_i;
  logic        rxfifo_wren_o;
  logic [31:0] rxfifo_data_o;

  modport slave (
    input  uart_rxvld_i,
    input  uart_rxdata_i,
    input  rxfifo_full_i,
    output rxfifo_wren_o,
    output rxfifo_data_o
  );

  modport master (
    output uart_rxvld_i,
    output uart_rxdata_i,
    output rxfifo_full_i,
    input  rxfifo_wren_o,
    input  rxfifo_data_o
  );

endinterface

// File: rtl/uart_rx_timeout.sv
// Line-idle timer: counts bit periods of baud_cnt_max_i clocks and pulses
// expire_o once TIMEOUT_BITS idle bit periods have elapsed.
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int TIMEOUT_BITS = UART_RX_TIMEOUT_BITS,
  parameter int TOCNT_W      = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        enable_i,
  input  logic        restart_i,
  input  logic [31:0] baud_cnt_max_i,
  output logic        expire_o
);

  logic [31:0]        r_inner;
  logic [TOCNT_W-1:0] r_outer;
  logic               w_run;
  logic               w_wrap;
  logic               w_last;

  assign w_run    = enable_i && !restart_i && (baud_cnt_max_i != 32'd0);
  // >= so a shrinking bit period mid-count still wraps at the next compare.
  assign w_wrap   = (r_inner >= (baud_cnt_max_i - 32'd1));
  assign w_last   = (r_outer == TOCNT_W'(TIMEOUT_BITS - 1));
  assign expire_o = w_run && w_wrap && w_last;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_inner <= 32'd0;
      r_outer <= '0;
    end else if (!w_run || expire_o) begin
      r_inner <= 32'd0;
      r_outer <= '0;
    end else if (w_wrap) begin
      r_inner <= 32'd0;
      r_outer <= r_outer + TOCNT_W'(1);
    end else begin
      r_inner <= r_inner + 32'd1;
    end
  end

endmodule

// File: rtl/uart_rx_pack.sv
// Packs UART RX bytes into 32-bit RX FIFO words (byte 0 in [7:0]).
// Define UART_RXPACK_TIMEOUT_EN to flush partial words after line idle.
module uart_rx_pack
  import uart_pkg::*;
#(
  parameter int TIMEOUT_BITS = UART_RX_TIMEOUT_BITS,
  parameter int TOCNT_W      = 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  uart_rx_pack_if.slave   bus,
  input  logic [31:0]     baud_cnt_max_i,
  input  logic            rx_ovf_clr_i,
  output logic [2:0]      rx_bytecnt_o,
  output logic            rx_ovf_o
);

  rxpack_state_e   r_state, w_state_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;
  logic [3:0][7:0] r_lanes, w_lanes_nxt;
  logic [31:0]     r_word, w_word_nxt;
  logic [7:0]      r_hold, w_hold_nxt;
  logic            r_hold_vld, w_hold_vld_nxt;
  logic            r_wren, w_wren_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic [2:0]      r_bytecnt;
  logic            w_drop;
  logic            w_expire;

`ifdef UART_RXPACK_TIMEOUT_EN
  logic w_to_en;
  logic w_to_restart;

  assign w_to_en      = (r_state == ST_COLLECT) && (r_cnt != 3'd0) &&
                        (r_cnt < 3'(UART_BYTES_PER_WORD));
  assign w_to_restart = bus.uart_rxvld_i || (r_cnt == 3'd0);

  uart_rx_timeout #(
    .TIMEOUT_BITS (TIMEOUT_BITS),
    .TOCNT_W      (TOCNT_W)
  ) u_timeout (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .enable_i       (w_to_en),
    .restart_i      (w_to_restart),
    .baud_cnt_max_i (baud_cnt_max_i),
    .expire_o       (w_expire)
  );
`else
  logic w_unused_baud;

  assign w_unused_baud = ^baud_cnt_max_i;
  assign w_expire      = 1'b0;
`endif

  // Next-state, lane packing, hold byte and overflow decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lanes_nxt    = r_lanes;
    w_word_nxt     = r_word;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_wren_nxt     = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (bus.uart_rxvld_i) begin
          w_lanes_nxt[r_cnt[1:0]] = bus.uart_rxdata_i;
          w_cnt_nxt               = r_cnt + 3'd1;
          if (r_cnt == 3'(UART_BYTES_PER_WORD - 1)) begin
            w_word_nxt  = w_lanes_nxt;
            w_lanes_nxt = '0;
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_COLLECT;
          end
        end else if (w_expire) begin
          w_word_nxt  = r_lanes;
          w_lanes_nxt = '0;
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if (!bus.rxfifo_full_i) begin
          w_wren_nxt     = 1'b1;
          w_state_nxt    = ST_COLLECT;
          w_lanes_nxt    = '0;
          w_hold_nxt     = 8'd0;
          w_hold_vld_nxt = 1'b0;
          // The held byte and any concurrent byte seed the next word in order.
          if (r_hold_vld) begin
            w_lanes_nxt[0] = r_hold;
            if (bus.uart_rxvld_i) begin
              w_lanes_nxt[1] = bus.uart_rxdata_i;
              w_cnt_nxt      = 3'd2;
            end else begin
              w_cnt_nxt      = 3'd1;
            end
          end else if (bus.uart_rxvld_i) begin
            w_lanes_nxt[0] = bus.uart_rxdata_i;
            w_cnt_nxt      = 3'd1;
          end else begin
            w_cnt_nxt      = 3'd0;
          end
        end else if (bus.uart_rxvld_i) begin
          if (!r_hold_vld) begin
            w_hold_nxt     = bus.uart_rxdata_i;
            w_hold_vld_nxt = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      default: begin
        w_state_nxt    = ST_COLLECT;
        w_cnt_nxt      = 3'd0;
        w_lanes_nxt    = '0;
        w_hold_vld_nxt = 1'b0;
      end
    endcase
    w_ovf_nxt = w_drop ? 1'b1 : (rx_ovf_clr_i ? 1'b0 : r_ovf);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_COLLECT;
      r_cnt      <= 3'd0;
      r_lanes    <= '0;
      r_word     <= 32'd0;
      r_hold     <= 8'd0;
      r_hold_vld <= 1'b0;
      r_wren     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bytecnt  <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lanes    <= w_lanes_nxt;
      r_word     <= w_word_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_wren     <= w_wren_nxt;
      r_ovf      <= w_ovf_nxt;
      r_bytecnt  <= held_bytes(w_cnt_nxt, w_hold_vld_nxt);
    end
  end

  assign bus.rxfifo_wren_o = r_wren;
  assign bus.rxfifo_data_o = r_word;
  assign rx_bytecnt_o      = r_bytecnt;
  assign rx_ovf_o          = r_ovf;

endmodule

// File: tb/tb_uart_rx_pack.sv
// Directed self-checking bench for uart_rx_pack (both UART_RXPACK_TIMEOUT_EN builds).
module tb_uart_rx_pack;

  logic        clk;
  logic        rstn;
  logic [31:0] baud_cnt_max;
  logic        ovf_clr;
  logic [2:0]  bytecnt;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int wren_cnt = 0;
  int base;
  int lat;

  uart_rx_pack_if u_if ();

  uart_rx_pack dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .bus            (u_if),
    .baud_cnt_max_i (baud_cnt_max),
    .rx_ovf_clr_i   (ovf_clr),
    .rx_bytecnt_o   (bytecnt),
    .rx_ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (u_if.rxfifo_wren_o) wren_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    u_if.uart_rxvld_i  = 1'b1;
    u_if.uart_rxdata_i = b;
    @(negedge clk);
    u_if.uart_rxvld_i  = 1'b0;
    u_if.uart_rxdata_i = 8'h00;
  endtask

  // lat = clock edges from the strobe's sampling edge to the edge sampling wren
  task automatic wait_wren(input int bound, output int l);
    l = 2;
    @(negedge clk);
    while (!u_if.rxfifo_wren_o && l < bound) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    baud_cnt_max = 32'd0;
    ovf_clr = 1'b0;
    u_if.uart_rxvld_i  = 1'b0;
    u_if.uart_rxdata_i = 8'h00;
    u_if.rxfifo_full_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wren", 32'(u_if.rxfifo_wren_o), 32'd0);
    check_eq("rst_data", u_if.rxfifo_data_o, 32'd0);
    check_eq("rst_bytecnt", 32'(bytecnt), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic 4-byte pack
    base = wren_cnt;
    send(8'h11); send(8'h22); send(8'h33);
    check_eq("t1_bytecnt3", 32'(bytecnt), 32'd3);
    send(8'h44);
    check_eq("t1_bytecnt4", 32'(bytecnt), 32'd4);
    wait_wren(20, lat);
    check_eq("t1_lat", 32'(lat), 32'd2);
    check_eq("t1_data", u_if.rxfifo_data_o, 32'h44332211);
    check_eq("t1_bytecnt0", 32'(bytecnt), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("t1_single_wren", 32'(wren_cnt - base), 32'd1);

    // Idle timeout with 25 clocks per bit
    baud_cnt_max = 32'd25;
    base = wren_cnt;
    send(8'hAA); send(8'hBB);
`ifdef UART_RXPACK_TIMEOUT_EN
    wait_wren(1100, lat);
    check_eq("t2_lat", 32'(lat), 32'd1002);
    check_eq("t2_data", u_if.rxfifo_data_o, 32'h0000BBAA);
    @(negedge clk);
    check_eq("t2_bytecnt0", 32'(bytecnt), 32'd0);
`else
    repeat (1100) @(negedge clk);
    check_eq("t2_no_wren", 32'(wren_cnt - base), 32'd0);
    check_eq("t2_bytecnt2", 32'(bytecnt), 32'd2);
    send(8'hCC); send(8'hDD);
    wait_wren(20, lat);
    check_eq("t2_lat", 32'(lat), 32'd2);
    check_eq("t2_data", u_if.rxfifo_data_o, 32'hDDCCBBAA);
`endif
    baud_cnt_max = 32'd0;
    @(negedge clk);

    // Back-pressure: hold byte plus concurrent byte seed next word
    u_if.rxfifo_full_i = 1'b1;
    base = wren_cnt;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    repeat (3) @(negedge clk);
    check_eq("t3_no_wren_full", 32'(wren_cnt - base), 32'd0);
    send(8'h55);
    check_eq("t3_bytecnt5", 32'(bytecnt), 32'd5);
    u_if.rxfifo_full_i = 1'b0;
    send(8'h66);
    check_eq("t3_wren", 32'(u_if.rxfifo_wren_o), 32'd1);
    check_eq("t3_data", u_if.rxfifo_data_o, 32'h04030201);
    check_eq("t3_bytecnt2", 32'(bytecnt), 32'd2);
    check_eq("t3_ovf", 32'(ovf), 32'd0);
    send(8'h77); send(8'h88);
    wait_wren(20, lat);
    check_eq("t3_lat", 32'(lat), 32'd2);
    check_eq("t3_data2", u_if.rxfifo_data_o, 32'h88776655);
    @(negedge clk);

    // Overflow set, clear, set-wins-over-clear
    u_if.rxfifo_full_i = 1'b1;
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    send(8'hB1);
    check_eq("t4_ovf_hold", 32'(ovf), 32'd0);
    send(8'hB2);
    check_eq("t4_ovf_set", 32'(ovf), 32'd1);
    check_eq("t4_bytecnt5", 32'(bytecnt), 32'd5);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("t4_ovf_clr", 32'(ovf), 32'd0);
    ovf_clr = 1'b1;
    send(8'hB3);
    ovf_clr = 1'b0;
    check_eq("t4_ovf_set_wins", 32'(ovf), 32'd1);
    u_if.rxfifo_full_i = 1'b0;
    wait_wren(20, lat);
    check_eq("t4_data", u_if.rxfifo_data_o, 32'hA4A3A2A1);
    check_eq("t4_bytecnt1", 32'(bytecnt), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    send(8'hC2); send(8'hC3); send(8'hC4);
    wait_wren(20, lat);
    check_eq("t4_data2", u_if.rxfifo_data_o, 32'hC4C3C2B1);
    check_eq("t4_ovf_final", 32'(ovf), 32'd0);
    @(negedge clk);

    // Timeout disabled by zero bit period
    baud_cnt_max = 32'd0;
    base = wren_cnt;
    send(8'h10); send(8'h20); send(8'h30);
    repeat (1200) @(negedge clk);
    check_eq("t5_no_flush", 32'(wren_cnt - base), 32'd0);
    check_eq("t5_bytecnt3", 32'(bytecnt), 32'd3);
    send(8'h40);
    wait_wren(20, lat);
    check_eq("t5_lat", 32'(lat), 32'd2);
    check_eq("t5_data", u_if.rxfifo_data_o, 32'h40302010);
    @(negedge clk);

    // Reset while in WRITE with FIFO full and hold valid
    u_if.rxfifo_full_i = 1'b1;
    send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
    send(8'hF1);
    check_eq("t6_bytecnt5", 32'(bytecnt), 32'd5);
    base = wren_cnt;
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t6_rst_bytecnt", 32'(bytecnt), 32'd0);
    check_eq("t6_rst_data", u_if.rxfifo_data_o, 32'd0);
    check_eq("t6_rst_wren", 32'(u_if.rxfifo_wren_o), 32'd0);
    @(negedge clk);
    u_if.rxfifo_full_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_no_wren", 32'(wren_cnt - base), 32'd0);
    check_eq("t6_post_bytecnt", 32'(bytecnt), 32'd0);
    send(8'h91); send(8'h92); send(8'h93); send(8'h94);
    wait_wren(20, lat);
    check_eq("t6_lat", 32'(lat), 32'd2);
    check_eq("t6_data", u_if.rxfifo_data_o, 32'h94939291);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
